tdm_channel_mux: RTL and testbench

- Parametrised successor to the fixed 16-bit/32-way registered channel selector in the D_CFIR datapath.
- Direct mode: registered random-access select of one channel, with an explicit out-of-range error.
- Scan mode: snapshots all N_CH channels on start, then serialises them one per cycle with valid/ready backpressure, channel tag and last flag.
- Sits between the parallel CFIR tap/channel outputs and the serial downstream (coefficient MAC / beam combiner).

---
 rtl/cfir_mux_pkg.sv | 17 +
 rtl/tdm_channel_mux.sv | 184 ++++++++++++++++++
 tb/tb_tdm_channel_mux.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cfir_mux_pkg.sv
// rtl/cfir_mux_pkg.sv - shared types, defaults and scan-length clamp for tdm_channel_mux
package cfir_mux_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_N_CH   = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // A zero or over-range scan length means "the whole bus".
    function automatic int eff_len(input int len, input int n_ch);
        return ((len == 0) || (len > n_ch)) ? n_ch : len;
    endfunction

endpackage

// File: rtl/tdm_channel_mux.sv
// rtl/tdm_channel_mux.sv - direct channel select / snapshot-and-serialise scan mux
//
// Ports:
//   clk, rst          clock, async active-high reset
//   mode              0 = direct select, 1 = scan (sampled only while idle)
//   sel, din_valid    direct-mode channel index and qualifier
//   din               flat channel bus, channel k at din[k*DATA_W +: DATA_W]
//   start, scan_len   scan frame start pulse and channel count from ch0
//   dout, dout_ch     sample and its channel index
//   dout_valid/last   output qualifier and final-channel-of-scan flag
//   dout_ready        downstream accept (scan mode only)
//   sel_err           direct select index beyond N_CH
//   busy              scan in progress
//   overrun, clr_overrun  sticky start-while-busy flag and its clear
module tdm_channel_mux
    import cfir_mux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int SEL_W  = $clog2(N_CH),
    parameter int CNT_W  = $clog2(N_CH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH*DATA_W-1:0] din,
    input  logic                   din_valid,
    input  logic                   start,
    input  logic [CNT_W-1:0]       scan_len,
    output logic [DATA_W-1:0]      dout,
    output logic [SEL_W-1:0]       dout_ch,
    output logic                   dout_valid,
    output logic                   dout_last,
    input  logic                   dout_ready,
    output logic                   sel_err,
    output logic                   busy,
    output logic                   overrun,
    input  logic                   clr_overrun
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   frame_q [N_CH];
    logic [CNT_W-1:0]    k_q, k_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                sel_err_q, sel_err_d;
    logic                overrun_q, overrun_d;

    logic [DATA_W-1:0]   dir_data;
    logic                dir_hit;
    logic [DATA_W-1:0]   frame_data;
    logic [CNT_W-1:0]    eff_k;
    logic                scan_start;

    // Explicit compare-per-channel mux: an out-of-range sel simply hits
    // nothing, which yields both the zero sample and the error flag.
    always_comb begin
        dir_data   = '0;
        dir_hit    = 1'b0;
        frame_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                dir_data = din[k*DATA_W +: DATA_W];
                dir_hit  = 1'b1;
            end
            if (idx_q == CNT_W'(k)) begin
                frame_data = frame_q[k];
            end
        end
    end

    assign eff_k      = CNT_W'(eff_len(int'(32'(scan_len)), N_CH));
    assign scan_start = (state_q == ST_IDLE) && mode && start;

    // Frame snapshot; contents are don't-care after reset, so no reset term.
    for (genvar g = 0; g < N_CH; g++) begin : g_frame
        always_ff @(posedge clk) begin
            if (scan_start) begin
                frame_q[g] <= din[g*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        idx_d     = idx_q;
        dout_d    = dout_q;
        ch_d      = ch_q;
        valid_d   = valid_q;
        last_d    = last_q;
        sel_err_d = sel_err_q;

        case (state_q)
            ST_IDLE: begin
                if (!mode) begin
                    dout_d    = dir_data;
                    ch_d      = sel;
                    valid_d   = din_valid;
                    last_d    = 1'b0;
                    sel_err_d = !dir_hit;
                end else if (start) begin
                    // ch0 goes straight from din so the first beat costs no extra cycle.
                    k_d       = eff_k;
                    dout_d    = din[DATA_W-1:0];
                    ch_d      = '0;
                    valid_d   = 1'b1;
                    last_d    = (eff_k == CNT_W'(1));
                    idx_d     = CNT_W'(1);
                    sel_err_d = 1'b0;
                    state_d   = ST_SCAN;
                end else begin
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                    sel_err_d = 1'b0;
                end
            end
            ST_SCAN: begin
                if (valid_q && dout_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (idx_q < k_q) begin
                        dout_d = frame_data;
                        ch_d   = SEL_W'(idx_q);
                        last_d = (idx_q == k_q - CNT_W'(1));
                        idx_d  = idx_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Set beats clear when a late start and a clear land on the same edge.
    always_comb begin
        overrun_d = overrun_q;
        if ((state_q == ST_SCAN) && start) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            idx_q     <= '0;
            dout_q    <= '0;
            ch_q      <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            sel_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            idx_q     <= idx_d;
            dout_q    <= dout_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            sel_err_q <= sel_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = ch_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_q;
    assign sel_err    = sel_err_q;
    assign busy       = (state_q == ST_SCAN);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tdm_channel_mux.sv
// tb/tb_tdm_channel_mux.sv - scoreboard bench for tdm_channel_mux (32- and 24-channel instances)
module tb_tdm_channel_mux;

    localparam int DW = 16;
    localparam int NA = 32;
    localparam int NB = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              mode_a, din_valid_a, start_a;
    logic [4:0]        sel_a;
    logic [5:0]        scan_len_a;
    logic [NA*DW-1:0]  din_a;
    logic [DW-1:0]     dout_a;
    logic [4:0]        dout_ch_a;
    logic              dout_valid_a, dout_last_a, sel_err_a, busy_a, overrun_a;

    logic              mode_b, din_valid_b, start_b;
    logic [4:0]        sel_b;
    logic [4:0]        scan_len_b;
    logic [NB*DW-1:0]  din_b;
    logic [DW-1:0]     dout_b;
    logic [4:0]        dout_ch_b;
    logic              dout_valid_b, dout_last_b, sel_err_b, busy_b, overrun_b;

    logic              dout_ready, clr_overrun;

    tdm_channel_mux #(.DATA_W(DW), .N_CH(NA)) u_dut_a (
        .clk(clk), .rst(rst), .mode(mode_a), .sel(sel_a), .din(din_a),
        .din_valid(din_valid_a), .start(start_a), .scan_len(scan_len_a),
        .dout(dout_a), .dout_ch(dout_ch_a), .dout_valid(dout_valid_a),
        .dout_last(dout_last_a), .dout_ready(dout_ready), .sel_err(sel_err_a),
        .busy(busy_a), .overrun(overrun_a), .clr_overrun(clr_overrun)
    );

    tdm_channel_mux #(.DATA_W(DW), .N_CH(NB)) u_dut_b (
        .clk(clk), .rst(rst), .mode(mode_b), .sel(sel_b), .din(din_b),
        .din_valid(din_valid_b), .start(start_b), .scan_len(scan_len_b),
        .dout(dout_b), .dout_ch(dout_ch_b), .dout_valid(dout_valid_b),
        .dout_last(dout_last_b), .dout_ready(dout_ready), .sel_err(sel_err_b),
        .busy(busy_b), .overrun(overrun_b), .clr_overrun(clr_overrun)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ent(input int d, input int ch, input logic last);
        logic [15:0] dd;
        logic [4:0]  cc;
        dd = 16'(d);
        cc = 5'(ch);
        return {10'b0, last, cc, dd};
    endfunction

    logic [31:0] q_a[$];
    logic        direct_a   = 1'b0;
    logic        hold_pend  = 1'b0;
    logic [15:0] hold_val   = '0;

    // Outputs sampled on the falling edge, well away from the rising edge that moves them.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("hold_a", {16'b0, dout_a}, {16'b0, hold_val});
            hold_pend = dout_valid_a && !dout_ready && !direct_a;
            hold_val  = dout_a;
            if (dout_valid_a && (dout_ready || direct_a)) begin
                if (q_a.size() == 0) begin
                    chk("sb_extra_a", 32'(q_a.size()), 32'd1);
                end else begin
                    chk("sb_a", {10'b0, dout_last_a, dout_ch_a, dout_a}, q_a.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan(input int k);
        for (int i = 0; i < k; i++) q_a.push_back(ent(16'h1000 + i, i, i == k - 1));
    endtask

    task automatic wait_idle_a(input string tag);
        for (int i = 0; i < 200 && busy_a; i++) step();
        chk(tag, {31'b0, busy_a}, 32'd0);
    endtask

    task automatic load_din_a(input logic ramp);
        for (int k = 0; k < NA; k++) din_a[k*DW +: DW] = ramp ? 16'(16'h1000 + k) : 16'hFFFF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int cnt;

    initial begin
        mode_a = 1'b1; din_valid_a = 1'b0; start_a = 1'b0; sel_a = '0; scan_len_a = '0;
        mode_b = 1'b1; din_valid_b = 1'b0; start_b = 1'b0; sel_b = '0; scan_len_b = '0;
        dout_ready = 1'b0; clr_overrun = 1'b0;
        load_din_a(1'b1);
        for (int k = 0; k < NB; k++) din_b[k*DW +: DW] = 16'(16'h1000 + k);

        step(); step();
        chk("rst_dout",    {16'b0, dout_a},  32'd0);
        chk("rst_ch",      {27'b0, dout_ch_a}, 32'd0);
        chk("rst_valid",   {31'b0, dout_valid_a}, 32'd0);
        chk("rst_last",    {31'b0, dout_last_a}, 32'd0);
        chk("rst_sel_err", {31'b0, sel_err_a}, 32'd0);
        chk("rst_busy",    {31'b0, busy_a}, 32'd0);
        chk("rst_overrun", {31'b0, overrun_a}, 32'd0);
        rst = 1'b0;
        step();

        // Direct select with ready low: ready must be ignored.
        direct_a = 1'b1; mode_a = 1'b0; din_valid_a = 1'b1;
        sel_a = 5'd0;  q_a.push_back(ent(16'h1000, 0, 1'b0)); step();
        sel_a = 5'd5;  q_a.push_back(ent(16'h1005, 5, 1'b0)); step();
        chk("direct_sel_err", {31'b0, sel_err_a}, 32'd0);
        sel_a = 5'd31; q_a.push_back(ent(16'h101F, 31, 1'b0)); step();
        din_valid_a = 1'b0; step();
        chk("direct_valid_off", {31'b0, dout_valid_a}, 32'd0);
        direct_a = 1'b0;
        chk("direct_drain", 32'(q_a.size()), 32'd0);

        // Full 32-channel scan at full rate.
        mode_a = 1'b1; dout_ready = 1'b1; scan_len_a = '0;
        start_a = 1'b1; push_scan(32); step(); start_a = 1'b0;
        chk("full_busy", {31'b0, busy_a}, 32'd1);
        repeat (31) step();
        chk("full_last_ch", {27'b0, dout_ch_a}, 32'd31);
        chk("full_last_flag", {31'b0, dout_last_a}, 32'd1);
        step();
        chk("full_busy_drop", {31'b0, busy_a}, 32'd0);
        chk("full_drain", 32'(q_a.size()), 32'd0);

        // Backpressure with din changing after the snapshot.
        scan_len_a = 6'd4;
        start_a = 1'b1; push_scan(4); step(); start_a = 1'b0;
        load_din_a(1'b0);
        for (int i = 0; i < 40 && busy_a; i++) begin
            dout_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        chk("bp_done", {31'b0, busy_a}, 32'd0);
        chk("bp_drain", 32'(q_a.size()), 32'd0);
        load_din_a(1'b1);
        dout_ready = 1'b1;

        // Overrun: late start is ignored but flagged.
        chk("ovr_init", {31'b0, overrun_a}, 32'd0);
        start_a = 1'b1; push_scan(4); step(); start_a = 1'b0;
        step();
        start_a = 1'b1; step(); start_a = 1'b0;
        chk("ovr_set", {31'b0, overrun_a}, 32'd1);
        wait_idle_a("ovr_idle");
        step();
        chk("ovr_len", 32'(q_a.size()), 32'd0);
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("ovr_clr", {31'b0, overrun_a}, 32'd0);
        start_a = 1'b1; push_scan(4); step();
        clr_overrun = 1'b1; step(); start_a = 1'b0; clr_overrun = 1'b0;
        chk("ovr_set_wins", {31'b0, overrun_a}, 32'd1);
        wait_idle_a("ovr_idle2");
        step();
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("ovr_clr2", {31'b0, overrun_a}, 32'd0);

        // Asynchronous reset while the third sample is on the output.
        scan_len_a = '0;
        start_a = 1'b1; push_scan(32); step(); start_a = 1'b0;
        step(); step();
        chk("mid_ch_pre", {27'b0, dout_ch_a}, 32'd2);
        rst = 1'b1; #1;
        chk("mid_dout",  {16'b0, dout_a}, 32'd0);
        chk("mid_ch",    {27'b0, dout_ch_a}, 32'd0);
        chk("mid_valid", {31'b0, dout_valid_a}, 32'd0);
        chk("mid_last",  {31'b0, dout_last_a}, 32'd0);
        chk("mid_busy",  {31'b0, busy_a}, 32'd0);
        q_a.delete();
        step(); rst = 1'b0; step();
        scan_len_a = 6'd2;
        start_a = 1'b1; push_scan(2); step(); start_a = 1'b0;
        wait_idle_a("post_rst_idle");
        step();
        chk("post_rst_drain", 32'(q_a.size()), 32'd0);

        // 24-channel instance: out-of-range select and clamped scan length.
        mode_b = 1'b0; din_valid_b = 1'b1; sel_b = 5'd27; step();
        chk("b_oor_dout",  {16'b0, dout_b}, 32'd0);
        chk("b_oor_err",   {31'b0, sel_err_b}, 32'd1);
        chk("b_oor_valid", {31'b0, dout_valid_b}, 32'd1);
        sel_b = 5'd23; step();
        chk("b_in_dout", {16'b0, dout_b}, 32'h1017);
        chk("b_in_err",  {31'b0, sel_err_b}, 32'd0);
        din_valid_b = 1'b0; mode_b = 1'b1; scan_len_b = 5'd30;
        start_b = 1'b1; step(); start_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60 && busy_b; i++) begin
            if (dout_valid_b) begin
                chk("b_scan_d",    {16'b0, dout_b}, 32'(16'h1000 + cnt));
                chk("b_scan_last", {31'b0, dout_last_b}, {31'b0, cnt == NB - 1});
                cnt++;
            end
            step();
        end
        chk("b_scan_count", 32'(cnt), 32'(NB));
        chk("b_scan_idle",  {31'b0, busy_b}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
